// File: rtl/return_addr_stack.sv
// Return address stack: circular buffer of link addresses with
// wrap-around on overflow, replace-top on simultaneous push/pop,
// and a highest-priority flush.
module return_addr_stack #(
  parameter int unsigned n     = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [n-1:0]               push_addr,
  input  logic                       pop,
  input  logic                       flush,
  output logic [n-1:0]               top_addr,
  output logic                       top_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [n-1:0]  mem_q [DEPTH];
  logic [PW-1:0] tos_q, tos_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          we_c;
  logic [PW-1:0] waddr_c;
  logic [n-1:0]  wdata_c;

  // Link addresses are halfword aligned; bit 0 is always stored as zero.
  assign wdata_c = {push_addr[n-1:1], 1'b0};

  // Next-state decode; flush wins, then push+pop, push, pop.
  always_comb begin
    tos_d       = tos_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    we_c        = 1'b0;
    waddr_c     = tos_q;
    if (flush) begin
      tos_d   = '0;
      count_d = '0;
    end else if (push && pop && (count_q != '0)) begin
      we_c    = 1'b1;
      waddr_c = tos_q;
    end else if (push) begin
      tos_d   = tos_q + PW'(1);
      we_c    = 1'b1;
      waddr_c = tos_q + PW'(1);
      if (count_q == CW'(DEPTH)) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else if (pop) begin
      if (count_q == '0) begin
        underflow_d = 1'b1;
      end else begin
        tos_d   = tos_q - PW'(1);
        count_d = count_q - CW'(1);
      end
    end
  end

  // Pointer, occupancy and event flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      tos_q       <= tos_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry storage; contents are unobservable while empty, so no reset.
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem_q[waddr_c] <= wdata_c;
    end
  end

  // Top entry is read straight from storage and masked when empty.
  assign top_addr  = (count_q != '0) ? mem_q[tos_q] : '0;
  assign top_valid = (count_q != '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack with hand-computed expectations.
module tb_return_addr_stack;

  logic        clk;
  logic        rst_n;
  logic        push;
  logic [31:0] push_addr;
  logic        pop;
  logic        flush;
  logic [31:0] top_addr;
  logic        top_valid;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int n_tests;
  int n_fail;

  return_addr_stack #(.n(32), .DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (push_addr),
    .pop       (pop),
    .flush     (flush),
    .top_addr  (top_addr),
    .top_valid (top_valid),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it; inputs then return to idle.
  task automatic step();
    @(posedge clk);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_push(input logic [31:0] a);
    push = 1'b1; push_addr = a;
    step();
  endtask

  task automatic do_pop();
    pop = 1'b1;
    step();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
  endtask

  task automatic chk_state(input string tag, input logic [31:0] t, input int c,
                           input logic o, input logic u);
    chk({tag, ".top"},   top_addr, t);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".valid"}, 32'(top_valid), 32'(c != 0));
    chk({tag, ".ovf"},   32'(overflow), 32'(o));
    chk({tag, ".unf"},   32'(underflow), 32'(u));
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; push_addr = '0;
    #12;
    chk_state("reset", 32'h0, 0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Basic push/push/pop.
    do_push(32'h0000_1008);
    chk_state("push1", 32'h1008, 1, 1'b0, 1'b0);
    do_push(32'h0000_2010);
    chk_state("push2", 32'h2010, 2, 1'b0, 1'b0);
    do_pop();
    chk_state("pop1", 32'h1008, 1, 1'b0, 1'b0);
    step();
    chk_state("idle", 32'h1008, 1, 1'b0, 1'b0);
    do_flush();
    chk_state("flush1", 32'h0, 0, 1'b0, 1'b0);

    // Nine pushes into eight entries: wrap-around on the last.
    for (int i = 0; i < 9; i++) begin
      do_push(32'h100 + 32'(8 * i));
      chk_state($sformatf("fill%0d", i), 32'h100 + 32'(8 * i),
                (i + 1 > 8) ? 8 : i + 1, i == 8, 1'b0);
    end
    step();
    chk_state("ovf_clear", 32'h140, 8, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d.top", k), top_addr, 32'h140 - 32'(8 * k));
      do_pop();
      chk($sformatf("drain%0d.count", k), 32'(count), 32'(7 - k));
    end
    chk_state("drained", 32'h0, 0, 1'b0, 1'b0);
    do_pop();
    chk_state("underflow", 32'h0, 0, 1'b0, 1'b1);
    step();
    chk_state("unf_clear", 32'h0, 0, 1'b0, 1'b0);

    // Replace-top with count = 3.
    do_push(32'h100); do_push(32'h200); do_push(32'h300);
    chk_state("three", 32'h300, 3, 1'b0, 1'b0);
    push = 1'b1; push_addr = 32'h400; pop = 1'b1;
    step();
    chk_state("replace", 32'h400, 3, 1'b0, 1'b0);
    do_pop();
    chk_state("replace_pop", 32'h200, 2, 1'b0, 1'b0);

    // Push and pop together on an empty stack.
    do_flush();
    push = 1'b1; push_addr = 32'h500; pop = 1'b1;
    step();
    chk_state("pushpop_empty", 32'h500, 1, 1'b0, 1'b0);

    // Flush beats a simultaneous push.
    do_flush();
    for (int i = 0; i < 5; i++) do_push(32'h1000 + 32'(i * 16));
    chk_state("five", 32'h1040, 5, 1'b0, 1'b0);
    flush = 1'b1; push = 1'b1; push_addr = 32'h600;
    step();
    chk_state("flush_push", 32'h0, 0, 1'b0, 1'b0);

    // Bit 0 of the link address is dropped.
    do_push(32'h0000_0707);
    chk_state("bit0", 32'h706, 1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a push.
    do_push(32'h0000_0808);
    chk_state("pre_rst", 32'h808, 2, 1'b0, 1'b0);
    push = 1'b1; push_addr = 32'h900;
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 32'h0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_state("rst_hold", 32'h0, 0, 1'b0, 1'b0);
    @(negedge clk);
    push = 1'b0; rst_n = 1'b1;
    #1;
    chk_state("rst_release", 32'h0, 0, 1'b0, 1'b0);
    do_push(32'h0000_0A00);
    chk_state("post_rst_push", 32'hA00, 1, 1'b0, 1'b0);
    do_pop();
    chk_state("post_rst_pop", 32'h0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Backstop so a stalled run still terminates with a report.
  initial begin
    #100000;
    $display("FAIL timeout: got 0x%08h, expected 0x%08h", 32'h1, 32'h0);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
